// File: rtl/transition_encoder_tx.sv
// rtl/transition_encoder_tx.sv - transition-based serial line encoder with optional bit stuffing
//
// Purpose:
//   Serialises WIDTH-bit words onto a single line using transition coding:
//   a 1 toggles the line, a 0 holds it.
//
//   The line level is kept across idle periods, so each new word is encoded
//   relative to wherever the line was left.
//
//   Defining TRANSITION_STUFF_EN inserts a forced toggle (stuff cycle) after
//   five consecutive 0 bits. This bounds the time between edges on the line.
//
// Parameters:
//   WIDTH      data bits per word (2..16)
//   LSB_FIRST  0 = MSB sent first, 1 = LSB sent first
//
// Ports:
//   Clk        clock, rising edge
//   Clr        asynchronous active-high reset
//   Din        word to encode
//   Din_valid  Din holds a valid word
//   Din_ready  word accepted this cycle when high together with Din_valid
//   Line       registered encoded line
//   Busy       high whenever the FSM is not idle
//   Stuff      high while Line shows a stuffed toggle (0 without TRANSITION_STUFF_EN)

module transition_encoder_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic             Line,
  output logic             Busy,
  output logic             Stuff
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef TRANSITION_STUFF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STUFF = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             line_nxt;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shift;

  // Bit about to be emitted and the register after it is consumed
  assign cur_bit     = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign shreg_shift = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};

  assign Busy      = (state != IDLE);
  assign Din_ready = (state == IDLE) && !Clr;

`ifdef TRANSITION_STUFF_EN
  logic [2:0] run_cnt, run_cnt_nxt;
  logic       stuff_nxt;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      Line    <= 1'b0;
      run_cnt <= 3'd0;
      Stuff   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      Line    <= line_nxt;
      run_cnt <= run_cnt_nxt;
      Stuff   <= stuff_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    line_nxt    = Line;
    run_cnt_nxt = run_cnt;
    stuff_nxt   = 1'b0;
    case (state)
      IDLE: begin
        run_cnt_nxt = 3'd0;
        if (Din_valid) begin
          shreg_nxt   = Din;
          bit_cnt_nxt = CNT_FULL;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        line_nxt    = Line ^ cur_bit;
        shreg_nxt   = shreg_shift;
        bit_cnt_nxt = bit_cnt - CNT_ONE;
        run_cnt_nxt = cur_bit ? 3'd0 : run_cnt + 3'd1;
        // The fifth zero in a row forces a stuff cycle, even after the last bit
        if (!cur_bit && run_cnt == 3'd4) begin
          state_nxt = STUFF;
        end else if (bit_cnt == CNT_ONE) begin
          state_nxt   = IDLE;
          run_cnt_nxt = 3'd0;
        end
      end
      STUFF: begin
        line_nxt    = ~Line;
        stuff_nxt   = 1'b1;
        run_cnt_nxt = 3'd0;
        state_nxt   = (bit_cnt == '0) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign Stuff = 1'b0;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      Line    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      Line    <= line_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    line_nxt    = Line;
    case (state)
      IDLE: begin
        if (Din_valid) begin
          shreg_nxt   = Din;
          bit_cnt_nxt = CNT_FULL;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        line_nxt    = Line ^ cur_bit;
        shreg_nxt   = shreg_shift;
        bit_cnt_nxt = bit_cnt - CNT_ONE;
        if (bit_cnt == CNT_ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`endif

endmodule

// File: tb/tb_transition_encoder_tx.sv
// tb/tb_transition_encoder_tx.sv - directed self-checking bench for transition_encoder_tx
module tb_transition_encoder_tx;

  logic       clk;
  logic       clr;
  logic [7:0] din;
  logic       din_valid;
  logic       m_ready, m_line, m_busy, m_stuff;
  logic       l_ready, l_line, l_busy, l_stuff;
  int         checks;
  int         errors;

  transition_encoder_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .Clk(clk), .Clr(clr), .Din(din), .Din_valid(din_valid),
    .Din_ready(m_ready), .Line(m_line), .Busy(m_busy), .Stuff(m_stuff)
  );

  transition_encoder_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .Clk(clk), .Clr(clr), .Din(din), .Din_valid(din_valid),
    .Din_ready(l_ready), .Line(l_line), .Busy(l_busy), .Stuff(l_stuff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [7:0]  exp_a5;
  logic [15:0] exp_z_line, exp_z_stuff, exp_tail;
  logic [7:0]  exp_ff_lsb;
  logic [7:0]  rec;
  logic        prev;
  int          n_zero, n_tail;

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    exp_a5 = 8'b11000110;
    exp_ff_lsb = 8'b10101010;
`ifdef TRANSITION_STUFF_EN
    n_zero      = 9;
    exp_z_line  = 16'b000001111;
    exp_z_stuff = 16'b000001000;
    n_tail      = 9;
    exp_tail    = 16'b111111000;
`else
    n_zero      = 8;
    exp_z_line  = 16'h0000;
    exp_z_stuff = 16'h0000;
    n_tail      = 8;
    exp_tail    = 16'h00FF;
`endif

    // Reset state
    step();
    chk("rst_line", 16'(m_line), 16'd0);
    chk("rst_ready", 16'(m_ready), 16'd0);
    chk("rst_busy", 16'(m_busy), 16'd0);
    chk("rst_stuff", 16'(m_stuff), 16'd0);
    chk("rst_lsb_line", 16'(l_line), 16'd0);
    clr = 1'b0;
    #1;
    chk("rel_ready", 16'(m_ready), 16'd1);

    // 8'hA5 MSB first
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    chk("a5_busy0", 16'(m_busy), 16'd1);
    chk("a5_ready0", 16'(m_ready), 16'd0);
    din_valid = 1'b0;
    prev = 1'b0;
    rec = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("a5_line%0d", i), 16'(m_line), 16'(exp_a5[7-i]));
      chk($sformatf("a5_busy%0d", i + 1), 16'(m_busy), 16'(i != 7));
      rec = {rec[6:0], prev ^ m_line};
      prev = m_line;
    end
    chk("a5_recover", 16'(rec), 16'h00A5);

    // 8'h00: all holds, or a stuffed toggle after five zeros
    din = 8'h00;
    din_valid = 1'b1;
    step();
    chk("z_busy0", 16'(m_busy), 16'd1);
    din_valid = 1'b0;
    for (int i = 0; i < n_zero; i++) begin
      step();
      chk($sformatf("z_line%0d", i), 16'(m_line), 16'(exp_z_line[n_zero-1-i]));
      chk($sformatf("z_stuff%0d", i), 16'(m_stuff), 16'(exp_z_stuff[n_zero-1-i]));
      chk($sformatf("z_busy%0d", i + 1), 16'(m_busy), 16'(i != n_zero - 1));
    end

    // Clr mid-idle, then accept on the first edge after release
    step();
    clr = 1'b1;
    #1;
    chk("ci_line", 16'(m_line), 16'd0);
    chk("ci_ready", 16'(m_ready), 16'd0);
    chk("ci_busy", 16'(m_busy), 16'd0);
    step();
    clr = 1'b0;
    din = 8'hFF;
    din_valid = 1'b1;
    #1;
    chk("ci_rel_ready", 16'(m_ready), 16'd1);

    // 8'hFF aborted by Clr after three bits
    step();
    chk("ff_accept_first_edge", 16'(m_busy), 16'd1);
    din_valid = 1'b0;
    step();
    chk("ff_line0", 16'(m_line), 16'd1);
    step();
    chk("ff_line1", 16'(m_line), 16'd0);
    step();
    chk("ff_line2", 16'(m_line), 16'd1);
    clr = 1'b1;
    #1;
    chk("ff_abort_line", 16'(m_line), 16'd0);
    chk("ff_abort_busy", 16'(m_busy), 16'd0);
    chk("ff_abort_ready", 16'(m_ready), 16'd0);
    chk("ff_abort_stuff", 16'(m_stuff), 16'd0);
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ff_quiet_line%0d", i), 16'(m_line), 16'd0);
      chk($sformatf("ff_quiet_busy%0d", i), 16'(m_busy), 16'd0);
    end

    // LSB first: hold Din_valid with 8'hFF, then 8'h01
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    chk("l_busy0", 16'(l_busy), 16'd1);
    din = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("l_ff_line%0d", i), 16'(l_line), 16'(exp_ff_lsb[7-i]));
    end
    chk("l_gap_ready", 16'(l_ready), 16'd1);
    chk("l_gap_busy", 16'(l_busy), 16'd0);
    step();
    chk("l_gap_line", 16'(l_line), 16'd0);
    chk("l_01_busy0", 16'(l_busy), 16'd1);
    chk("l_01_ready0", 16'(l_ready), 16'd0);
    din_valid = 1'b0;
    for (int i = 0; i < n_tail; i++) begin
      step();
      chk($sformatf("l_01_line%0d", i), 16'(l_line), 16'(exp_tail[n_tail-1-i]));
      chk($sformatf("l_01_busy%0d", i + 1), 16'(l_busy), 16'(i != n_tail - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
